// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and enums for the register-file write-port controller.
package regfile_pkg;
   localparam int REG_ADDR_W = 4;
   localparam int REG_DATA_W = 16;
   localparam int NUM_REGS   = 16;

   typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} wr_state_t;
   typedef enum logic [0:0] {REQ_ALU = 1'b0, REQ_LD = 1'b1} req_id_t;
endpackage

// File: rtl/regfile_wr_ctrl_if.sv
// regfile_wr_ctrl_if: requester, clear-control and register-file write bus of the write-port controller.
interface regfile_wr_ctrl_if #(
   parameter int DATA_W = regfile_pkg::REG_DATA_W,
   parameter int ADDR_W = regfile_pkg::REG_ADDR_W
) ();
   logic              clear_req;
   logic              clear_busy;
   logic              alu_req;
   logic [ADDR_W-1:0] alu_sel;
   logic [DATA_W-1:0] alu_data;
   logic              alu_gnt;
   logic              ld_req;
   logic [ADDR_W-1:0] ld_sel;
   logic [DATA_W-1:0] ld_data;
   logic              ld_gnt;
   logic              rf_write;
   logic [ADDR_W-1:0] rf_sel;
   logic [DATA_W-1:0] rf_data;

   modport master (
      output clear_req, alu_req, alu_sel, alu_data, ld_req, ld_sel, ld_data,
      input  clear_busy, alu_gnt, ld_gnt, rf_write, rf_sel, rf_data
   );

   modport slave (
      input  clear_req, alu_req, alu_sel, alu_data, ld_req, ld_sel, ld_data,
      output clear_busy, alu_gnt, ld_gnt, rf_write, rf_sel, rf_data
   );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with combinational grants and a last-winner flop.
module rr_arb2
   import regfile_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic req_alu,
   input  logic req_ld,
   input  logic grant_en,
   input  logic upd_en,
   output logic gnt_alu,
   output logic gnt_ld
);
   req_id_t last_r;

   // On conflict the requester that did not win last time is served.
   always_comb begin
      gnt_alu = 1'b0;
      gnt_ld  = 1'b0;
      if (!grant_en) begin
         gnt_alu = 1'b0;
         gnt_ld  = 1'b0;
      end else if (req_alu && req_ld) begin
         if (last_r == REQ_LD) begin
            gnt_alu = 1'b1;
         end else begin
            gnt_ld = 1'b1;
         end
      end else begin
         gnt_alu = req_alu;
         gnt_ld  = req_ld;
      end
   end

   // Last-winner pointer; starts at LD so the ALU wins the first conflict.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_r <= REQ_LD;
      end else if (upd_en) begin
         last_r <= gnt_alu ? REQ_ALU : REQ_LD;
      end else begin
         last_r <= last_r;
      end
   end
endmodule

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl: register-file write-port arbiter with a hardware clear walk over all registers.
// Optional REGFILE_R0_PROTECT_EN suppresses granted writes to R0 so it stays zero.
module regfile_wr_ctrl
   import regfile_pkg::*;
#(
   parameter int DATA_W         = REG_DATA_W,
   parameter int ADDR_W         = REG_ADDR_W,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   regfile_wr_ctrl_if.slave  bus
);
   localparam logic [ADDR_W-1:0] CNT_LAST    = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] CNT_ONE     = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam wr_state_t         RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

   wr_state_t         state_r;
   wr_state_t         state_nx_s;
   logic [ADDR_W-1:0] count_r;
   logic [ADDR_W-1:0] count_nx_s;
   logic              rf_write_r;
   logic [ADDR_W-1:0] rf_sel_r;
   logic [DATA_W-1:0] rf_data_r;
   logic              clear_busy_r;
   logic              wr_nx_s;
   logic [ADDR_W-1:0] sel_nx_s;
   logic [DATA_W-1:0] data_nx_s;
   logic              gnt_alu_s;
   logic              gnt_ld_s;
   logic              grant_en_s;
   logic              accept_s;
   logic [ADDR_W-1:0] win_sel_s;
   logic [DATA_W-1:0] win_data_s;
   logic              win_write_s;

   // Grants are only possible in IDLE, out of reset, and when no clear is being requested.
   assign grant_en_s = reset && (state_r == ST_IDLE) && !bus.clear_req;
   assign accept_s   = gnt_alu_s || gnt_ld_s;

   rr_arb2 u_arb (
      .clk      (clk),
      .reset    (reset),
      .req_alu  (bus.alu_req),
      .req_ld   (bus.ld_req),
      .grant_en (grant_en_s),
      .upd_en   (accept_s),
      .gnt_alu  (gnt_alu_s),
      .gnt_ld   (gnt_ld_s)
   );

   assign win_sel_s  = gnt_alu_s ? bus.alu_sel  : bus.ld_sel;
   assign win_data_s = gnt_alu_s ? bus.alu_data : bus.ld_data;

`ifdef REGFILE_R0_PROTECT_EN
   assign win_write_s = (win_sel_s != {ADDR_W{1'b0}});
`else
   assign win_write_s = 1'b1;
`endif

   // Next-state and next-output logic for the clear walk and the arbitrated write path.
   always_comb begin
      state_nx_s = state_r;
      count_nx_s = count_r;
      wr_nx_s    = 1'b0;
      sel_nx_s   = rf_sel_r;
      data_nx_s  = rf_data_r;
      case (state_r)
         ST_CLEAR: begin
            wr_nx_s   = 1'b1;
            sel_nx_s  = count_r;
            data_nx_s = {DATA_W{1'b0}};
            if (count_r == CNT_LAST) begin
               state_nx_s = ST_IDLE;
               count_nx_s = {ADDR_W{1'b0}};
            end else begin
               count_nx_s = count_r + CNT_ONE;
            end
         end
         ST_IDLE: begin
            if (bus.clear_req) begin
               state_nx_s = ST_CLEAR;
               count_nx_s = {ADDR_W{1'b0}};
            end else if (accept_s) begin
               wr_nx_s   = win_write_s;
               sel_nx_s  = win_sel_s;
               data_nx_s = win_data_s;
            end else begin
               wr_nx_s = 1'b0;
            end
         end
         default: begin
            state_nx_s = ST_CLEAR;
            count_nx_s = {ADDR_W{1'b0}};
         end
      endcase
   end

   // State, clear counter and registered register-file drive.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r      <= RESET_STATE;
         count_r      <= {ADDR_W{1'b0}};
         rf_write_r   <= 1'b0;
         rf_sel_r     <= {ADDR_W{1'b0}};
         rf_data_r    <= {DATA_W{1'b0}};
         clear_busy_r <= (RESET_STATE == ST_CLEAR);
      end else begin
         state_r      <= state_nx_s;
         count_r      <= count_nx_s;
         rf_write_r   <= wr_nx_s;
         rf_sel_r     <= sel_nx_s;
         rf_data_r    <= data_nx_s;
         clear_busy_r <= (state_nx_s == ST_CLEAR);
      end
   end

   assign bus.alu_gnt    = gnt_alu_s;
   assign bus.ld_gnt     = gnt_ld_s;
   assign bus.rf_write   = rf_write_r;
   assign bus.rf_sel     = rf_sel_r;
   assign bus.rf_data    = rf_data_r;
   assign bus.clear_busy = clear_busy_r;
endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// tb_regfile_wr_ctrl: directed table, multi-cycle clear/reset sequences and a randomized
// phase checked against a cycle-level behavioural model of the write-port controller.
module tb_regfile_wr_ctrl;
   import regfile_pkg::*;

`ifdef REGFILE_R0_PROTECT_EN
   localparam bit R0P = 1'b1;
`else
   localparam bit R0P = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_pass = 0;
   int   n_total = 0;

   regfile_wr_ctrl_if #(.DATA_W(16), .ADDR_W(4)) bus ();

   regfile_wr_ctrl #(.DATA_W(16), .ADDR_W(4), .CLEAR_ON_RESET(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ar;
      logic [3:0]  as;
      logic [15:0] ad;
      logic        lr;
      logic [3:0]  ls;
      logic [15:0] ld;
      logic        clr;
      logic        eg_a;
      logic        eg_l;
      logic        ewr;
      logic        chk_bus;
      logic [3:0]  esel;
      logic [15:0] edat;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input logic ar, input logic [3:0] as, input logic [15:0] ad,
                        input logic lr, input logic [3:0] ls, input logic [15:0] ld,
                        input logic clr);
      bus.alu_req   = ar;
      bus.alu_sel   = as;
      bus.alu_data  = ad;
      bus.ld_req    = lr;
      bus.ld_sel    = ls;
      bus.ld_data   = ld;
      bus.clear_req = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rf(input string name, input logic wr, input logic [3:0] sel,
                         input logic [15:0] dat);
      chk({name, "_wr"}, 32'(bus.rf_write), 32'(wr));
      chk({name, "_sel"}, 32'(bus.rf_sel), 32'(sel));
      chk({name, "_data"}, 32'(bus.rf_data), 32'(dat));
   endtask

   // Behavioural model state for the randomized phase
   bit          m_clearing;
   int          m_walk;
   bit          m_last_alu;
   bit          m_known;
   bit          e_wr;
   int          e_sel;
   int          e_data;

   initial begin
      tbl[0]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 16'h0000};
      tbl[1]  = '{1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 16'hBEEF};
      tbl[2]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd5, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 16'h1234};
      tbl[3]  = '{1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'h1111};
      tbl[4]  = '{1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 16'h2222};
      tbl[5]  = '{1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 16'h1111};
      tbl[6]  = '{1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 16'h2222};
      tbl[7]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 16'h2222};
      tbl[8]  = '{1'b1, 4'd0, 16'h00FF, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b0, !R0P, !R0P, 4'd0, 16'h00FF};
      tbl[9]  = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd15, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 16'hABCD};
      tbl[10] = '{1'b1, 4'd7, 16'h7777, 1'b1, 4'd8, 16'h8888, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 16'h7777};
      tbl[11] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd8, 16'h8888, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 16'h7777};

      // Reset with requests pending: grants must stay low
      reset = 1'b0;
      drive(1'b1, 4'd4, 16'h4444, 1'b1, 4'd5, 16'h5555, 1'b0);
      repeat (3) tick();
      #4;
      chk("rst_alu_gnt", 32'(bus.alu_gnt), 32'd0);
      chk("rst_ld_gnt", 32'(bus.ld_gnt), 32'd0);
      tick();
      chk_rf("rst", 1'b0, 4'd0, 16'h0000);
      chk("rst_busy", 32'(bus.clear_busy), 32'd1);

      // Release reset with no traffic: full zero walk
      drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0);
      reset = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk_rf("walk", 1'b1, 4'(i), 16'h0000);
         chk("walk_busy", 32'(bus.clear_busy), 32'(i < 15));
      end

      // Directed table from IDLE with the pointer at LD
      for (int v = 0; v < 12; v++) begin
         drive(tbl[v].ar, tbl[v].as, tbl[v].ad, tbl[v].lr, tbl[v].ls, tbl[v].ld, tbl[v].clr);
         #4;
         chk($sformatf("tbl%0d_alu_gnt", v), 32'(bus.alu_gnt), 32'(tbl[v].eg_a));
         chk($sformatf("tbl%0d_ld_gnt", v), 32'(bus.ld_gnt), 32'(tbl[v].eg_l));
         tick();
         chk($sformatf("tbl%0d_wr", v), 32'(bus.rf_write), 32'(tbl[v].ewr));
         if (tbl[v].chk_bus) begin
            chk($sformatf("tbl%0d_sel", v), 32'(bus.rf_sel), 32'(tbl[v].esel));
            chk($sformatf("tbl%0d_data", v), 32'(bus.rf_data), 32'(tbl[v].edat));
         end
      end

      // Clear during traffic: LD held high through the whole walk
      drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd8, 16'h8888, 1'b0);
      for (int i = 0; i < 16; i++) begin
         #4;
         chk("ctr_ld_gnt_low", 32'(bus.ld_gnt), 32'd0);
         tick();
         chk_rf("ctr_walk", 1'b1, 4'(i), 16'h0000);
      end
      #4;
      chk("ctr_ld_gnt_back", 32'(bus.ld_gnt), 32'd1);
      tick();
      chk_rf("ctr_ld_write", 1'b1, 4'd8, 16'h8888);

      // Reset in the middle of a clear walk restarts it from R0
      drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1);
      tick();
      drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0);
      repeat (7) tick();
      chk("mid_sel6", 32'(bus.rf_sel), 32'd6);
      reset = 1'b0;
      repeat (2) tick();
      chk_rf("mid_rst", 1'b0, 4'd0, 16'h0000);
      reset = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk_rf("mid_walk", 1'b1, 4'(i), 16'h0000);
      end
      chk("mid_busy_done", 32'(bus.clear_busy), 32'd0);

      // Randomized phase against the behavioural model, starting from a fresh reset
      begin
         bit          a_req, l_req, clr, rst_now, g_alu, g_ld, a_pend, l_pend, ok;
         logic [3:0]  a_sel, l_sel;
         logic [15:0] a_dat, l_dat;
         a_pend = 1'b0; l_pend = 1'b0;
         a_req = 1'b0; l_req = 1'b0; a_sel = 4'd0; l_sel = 4'd0; a_dat = 16'h0; l_dat = 16'h0;
         reset = 1'b0;
         drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0);
         repeat (2) tick();
         m_clearing = 1'b1; m_walk = 0; m_last_alu = 1'b0; m_known = 1'b1;
         e_wr = 1'b0; e_sel = 0; e_data = 0;
         reset = 1'b1;
         for (int c = 0; c < 1500; c++) begin
            if (!a_pend) begin
               a_req = ($urandom_range(99) < 60);
               a_sel = 4'($urandom_range(15));
               a_dat = 16'($urandom);
            end
            if (!l_pend) begin
               l_req = ($urandom_range(99) < 60);
               l_sel = 4'($urandom_range(15));
               l_dat = 16'($urandom);
            end
            clr = ($urandom_range(99) < 3);
            rst_now = ($urandom_range(199) < 1);
            reset = !rst_now;
            drive(a_req, a_sel, a_dat, l_req, l_sel, l_dat, clr);
            #4;
            ok = !rst_now && !m_clearing && !clr;
            if (ok && a_req && l_req) begin
               g_alu = !m_last_alu;
               g_ld  = m_last_alu;
            end else begin
               g_alu = ok && a_req;
               g_ld  = ok && l_req && !a_req;
            end
            chk("rnd_alu_gnt", 32'(bus.alu_gnt), 32'(g_alu));
            chk("rnd_ld_gnt", 32'(bus.ld_gnt), 32'(g_ld));
            tick();
            if (rst_now) begin
               m_clearing = 1'b1; m_walk = 0; m_last_alu = 1'b0; m_known = 1'b1;
               e_wr = 1'b0; e_sel = 0; e_data = 0;
            end else if (m_clearing) begin
               e_wr = 1'b1; e_sel = m_walk; e_data = 0; m_known = 1'b1;
               m_walk++;
               if (m_walk == 16) m_clearing = 1'b0;
            end else if (clr) begin
               m_clearing = 1'b1; m_walk = 0; e_wr = 1'b0;
            end else if (g_alu || g_ld) begin
               e_sel  = g_alu ? int'(a_sel) : int'(l_sel);
               e_data = g_alu ? int'(a_dat) : int'(l_dat);
               m_last_alu = g_alu;
               if (R0P && e_sel == 0) begin
                  e_wr = 1'b0; m_known = 1'b0;
               end else begin
                  e_wr = 1'b1; m_known = 1'b1;
               end
            end else begin
               e_wr = 1'b0;
            end
            a_pend = a_req && !g_alu;
            l_pend = l_req && !g_ld;
            chk("rnd_wr", 32'(bus.rf_write), 32'(e_wr));
            chk("rnd_busy", 32'(bus.clear_busy), 32'(m_clearing));
            if (m_known) begin
               chk("rnd_sel", 32'(bus.rf_sel), 32'(e_sel));
               chk("rnd_data", 32'(bus.rf_data), 32'(e_data));
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
